id_ex_issue: RTL and testbench
==============================

// Module: id_ex_issue
// PURPOSE
//  ID->EX issue stage: the producer end of the ALU operand interface. Decodes RV32I instr, builds
//  immediate, resolves operands via forwarding, registers alu_in1/alu_in2/alu_op/alu_invert.
//  Sits between fetch/decode (regfile read) and the EX-stage ALU; valid/ready both sides;
//  stalls on load-use, drops on flush.
// PARAMETERS
//  XLEN     32  datapath width
//  RA_W     5   register address width
// PORTS
//  clk           in   1     clock; all state on rising edge
//  reset         in   1     synchronous, active-high
//  flush         in   1     kill incoming + registered instr (branch redirect)
//  id_valid      in   1     ID offers instr
//  id_ready      out  1     issue accepts instr this cycle
//  id_instr      in   32    raw instruction
//  id_pc         in   XLEN  instruction PC
//  id_rs1_data   in   XLEN  regfile rs1 read
//  id_rs2_data   in   XLEN  regfile rs2 read
//  ex_alu_out    in   XLEN  ALU result of instr held in this block's output reg
//  mem_rd/mem_we/mem_result  in  RA_W/1/XLEN  MEM-stage writeback info
//  wb_rd/wb_we/wb_result     in  RA_W/1/XLEN  WB-stage writeback info
//  ex_valid      out  1     output reg holds a live instr
//  ex_ready      in   1     EX consumes output reg
//  alu_in1, alu_in2 out XLEN  ALU operands
//  alu_op        out  3     ALU opcode (=funct3 encoding of ALU)
//  alu_invert    out  1     SUB / SRA / branch-EQ select
//  ex_rd/ex_we   out  RA_W/1  destination, writes-back flag (0 if rd==x0)
//  ex_is_load/ex_is_store/ex_is_branch/ex_is_jump  out 1  class flags
//  ex_funct3     out  3     mem size / branch cond
//  ex_store_data out  XLEN  forwarded rs2 for stores
//  ex_imm/ex_pc  out  XLEN  for branch target unit
//  ex_illegal    out  1     unsupported opcode
// BEHAVIOUR
//  - Reset: every output reg 0, ex_valid=0. id_ready is comb; low during reset cycle.
//  - Occupancy FSM EMPTY(ex_valid=0)/FULL(ex_valid=1). Load when id_valid&&id_ready.
//    FULL->EMPTY on ex_ready w/o load. Hold all outputs stable while ex_valid&&!ex_ready.
//  - id_ready = (!ex_valid || ex_ready) && !hazard && !flush.
//  - hazard (load-use): ex_valid && ex_is_load && ex_rd!=0 && ex_rd matches a used rs1/rs2.
//    Stall 1+ cycles; bubble (ex_valid=0) when ex_ready.
//  - Forwarding per rs (x0 never forwarded, always 0), priority EX > MEM > WB > regfile.
//    EX src: ex_valid&&ex_we&&!ex_is_load, data ex_alu_out.
//  - Operand map (alu_op, invert):
//    OP: funct3, invert=f7[5] for 000/101.  OP-IMM: funct3, imm; invert=f7[5] only for 101.
//    LUI: 0+imm, add. AUIPC: pc+imm, add. LOAD/STORE: rs1+imm, add.
//    JAL/JALR: pc+4, add.
//    BRANCH: BEQ/BNE 000 inv=1 (zero flag); BLT/BGE 010; BLTU/BGEU 011; in2=rs2.
//    SLT/SLTU: invert=0.
//  - Unknown opcode: ex_illegal=1, ex_we=0, alu_op=000, operands 0; still issued.
//  - Imm formats I/S/B/U/J, sign-extended to XLEN; shifts use imm[4:0], upper bits 0.
//  - Latency: 1 cycle ID accept -> registered outputs.
//  - flush: next cycle ex_valid=0, incoming dropped; flush beats load and ex_ready.
//  - Reset mid-stall: reset wins; EMPTY next cycle.
// STRUCTURE
//  - riscv_pkg: opcode constants, alu_op_e (ADD..AND), fwd_sel_e {FWD_RF,FWD_EX,FWD_MEM,FWD_WB},
//    imm_fmt_e.
//  - Sub-module rv_imm_gen (comb: instr -> imm, fmt); forwarding muxes + FSM inline.
// TESTING
//  - ADD x3,x1,x2 rs1=5 rs2=7, ex_ready=1 -> next cycle alu_in1=5 in2=7 op=000 inv=0 ex_rd=3.
//  - SUB x4,x3,x1, x3 in EX (ex_alu_out=12) -> alu_in1=12 (EX fwd beats MEM/WB writing x3).
//  - LW x5,0(x1) then ADD x6,x5,x5 -> id_ready=0 one cycle, bubble, ADD then takes MEM fwd.
//  - ex_ready=0 for 3 cycles while FULL -> outputs stable, id_ready=0; release -> next accepted.
//  - BLTU x1,x2 -> op=011 inv=0; SRAI x1,3 -> op=101 inv=1 in2=3; x0 src -> 0 despite wb_rd=0.
//  - flush with id_valid=1 and FULL -> ex_valid=0 next cycle; reset while stalled -> all 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and enums for the ID->EX issue stage.
package riscv_pkg;

    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // ALU opcode uses the OP/OP-IMM funct3 encoding directly
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef enum logic {
        ISS_EMPTY = 1'b0,
        ISS_FULL  = 1'b1
    } iss_state_e;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate extraction: format from opcode, 32-bit sign-extended value.
module rv_imm_gen
    import riscv_pkg::*;
(
    input  logic [ILEN-1:0] instr,
    output logic [ILEN-1:0] imm_c,
    output imm_fmt_e        fmt_c
);

    logic [6:0] opcode;
    assign opcode = instr[6:0];

    // Classify the immediate format by opcode
    always_comb begin
        fmt_c = IMM_NONE;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt_c = IMM_I;
            OPC_STORE:                      fmt_c = IMM_S;
            OPC_BRANCH:                     fmt_c = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt_c = IMM_U;
            OPC_JAL:                        fmt_c = IMM_J;
            default:                        fmt_c = IMM_NONE;
        endcase
    end

    // Assemble the immediate; shift-immediates (funct3 x01) keep only the shamt
    always_comb begin
        imm_c = {{20{instr[31]}}, instr[31:20]};
        case (fmt_c)
            IMM_I: begin
                if (opcode == OPC_OP_IMM && instr[13:12] == 2'b01) begin
                    imm_c = {27'b0, instr[24:20]};
                end
            end
            IMM_S: imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm_c = {instr[31:12], 12'b0};
            IMM_J: imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_c = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

endmodule

// File: rtl/id_ex_issue.sv
// ID->EX issue stage: decode, immediate, operand forwarding and the registered ALU operand slot.
module id_ex_issue
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [2:0]      alu_op,
    output logic            alu_invert,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_we,
    output logic            ex_is_load,
    output logic            ex_is_store,
    output logic            ex_is_branch,
    output logic            ex_is_jump,
    output logic [2:0]      ex_funct3,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);

    function automatic fwd_sel_e fwd_pick(
        input logic [RA_W-1:0] rs,
        input logic            ex_ok,
        input logic [RA_W-1:0] e_rd,
        input logic            m_we,
        input logic [RA_W-1:0] m_rd,
        input logic            w_we,
        input logic [RA_W-1:0] w_rd
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (rs == '0)                     sel = FWD_RF;
        else if (ex_ok && e_rd == rs)     sel = FWD_EX;
        else if (m_we && m_rd == rs)      sel = FWD_MEM;
        else if (w_we && w_rd == rs)      sel = FWD_WB;
        return sel;
    endfunction

    function automatic logic [XLEN-1:0] fwd_data(
        input fwd_sel_e        sel,
        input logic            rs_zero,
        input logic [XLEN-1:0] rf,
        input logic [XLEN-1:0] ex,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] wb
    );
        logic [XLEN-1:0] val;
        case (sel)
            FWD_EX:  val = ex;
            FWD_MEM: val = mem;
            FWD_WB:  val = wb;
            default: val = rf;
        endcase
        if (rs_zero) val = '0;
        return val;
    endfunction

    iss_state_e      state_q;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            f7b5;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [ILEN-1:0] imm_raw_c;
    imm_fmt_e        imm_fmt_c;
    logic [XLEN-1:0] imm_x;
    fwd_sel_e        rs1_sel, rs2_sel;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            ex_src_ok;

    logic [XLEN-1:0] d_in1, d_in2;
    alu_op_e         d_op;
    logic            d_inv, d_wr, d_load, d_store, d_branch, d_jump, d_illegal;
    logic            use_rs1, use_rs2, rd_wr, hazard, load_en;

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign f7b5   = id_instr[30];
    assign rs1    = RA_W'(id_instr[19:15]);
    assign rs2    = RA_W'(id_instr[24:20]);
    assign rd     = RA_W'(id_instr[11:7]);

    rv_imm_gen u_imm_gen (
        .instr (id_instr),
        .imm_c (imm_raw_c),
        .fmt_c (imm_fmt_c)
    );

    assign imm_x = (imm_fmt_c == IMM_NONE) ? '0 : XLEN'($signed(imm_raw_c));

    // Operand forwarding: EX > MEM > WB > regfile, x0 always reads zero
    assign ex_src_ok = ex_valid && ex_we && !ex_is_load;
    assign rs1_sel   = fwd_pick(rs1, ex_src_ok, ex_rd, mem_we, mem_rd, wb_we, wb_rd);
    assign rs2_sel   = fwd_pick(rs2, ex_src_ok, ex_rd, mem_we, mem_rd, wb_we, wb_rd);
    assign rs1_val   = fwd_data(rs1_sel, rs1 == '0, id_rs1_data, ex_alu_out, mem_result, wb_result);
    assign rs2_val   = fwd_data(rs2_sel, rs2 == '0, id_rs2_data, ex_alu_out, mem_result, wb_result);

    // Decode into ALU operands, opcode and class flags
    always_comb begin
        d_in1     = '0;
        d_in2     = '0;
        d_op      = ALU_ADD;
        d_inv     = 1'b0;
        d_wr      = 1'b0;
        d_load    = 1'b0;
        d_store   = 1'b0;
        d_branch  = 1'b0;
        d_jump    = 1'b0;
        d_illegal = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_in1   = rs1_val;
                d_in2   = rs2_val;
                d_op    = alu_op_e'(funct3);
                d_inv   = f7b5 && (funct3 == 3'b000 || funct3 == 3'b101);
                d_wr    = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                d_in1   = rs1_val;
                d_in2   = imm_x;
                d_op    = alu_op_e'(funct3);
                d_inv   = f7b5 && (funct3 == 3'b101);
                d_wr    = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_LUI: begin
                d_in2 = imm_x;
                d_wr  = 1'b1;
            end
            OPC_AUIPC: begin
                d_in1 = id_pc;
                d_in2 = imm_x;
                d_wr  = 1'b1;
            end
            OPC_LOAD: begin
                d_in1   = rs1_val;
                d_in2   = imm_x;
                d_wr    = 1'b1;
                d_load  = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                d_in1   = rs1_val;
                d_in2   = imm_x;
                d_store = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_JAL: begin
                d_in1  = id_pc;
                d_in2  = XLEN'(4);
                d_wr   = 1'b1;
                d_jump = 1'b1;
            end
            OPC_JALR: begin
                d_in1   = id_pc;
                d_in2   = XLEN'(4);
                d_wr    = 1'b1;
                d_jump  = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                d_in1    = rs1_val;
                d_in2    = rs2_val;
                d_branch = 1'b1;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                case (funct3[2:1])
                    2'b10:   d_op = ALU_SLT;
                    2'b11:   d_op = ALU_SLTU;
                    default: begin
                        d_op  = ALU_ADD;
                        d_inv = 1'b1;
                    end
                endcase
            end
            default: d_illegal = 1'b1;
        endcase
    end

    // Load-use stall and the upstream handshake
    assign rd_wr    = d_wr && (rd != '0);
    assign hazard   = ex_valid && ex_is_load && (ex_rd != '0) &&
                      ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));
    assign id_ready = !reset && (!ex_valid || ex_ready) && !hazard && !flush;
    assign load_en  = id_valid && id_ready;
    assign ex_valid = (state_q == ISS_FULL);

    // Occupancy FSM and output register; flush beats load and drain
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ISS_EMPTY;
            alu_in1       <= '0;
            alu_in2       <= '0;
            alu_op        <= 3'b000;
            alu_invert    <= 1'b0;
            ex_rd         <= '0;
            ex_we         <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_is_store   <= 1'b0;
            ex_is_branch  <= 1'b0;
            ex_is_jump    <= 1'b0;
            ex_funct3     <= 3'b000;
            ex_store_data <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
            ex_illegal    <= 1'b0;
        end else if (flush) begin
            state_q <= ISS_EMPTY;
        end else if (load_en) begin
            state_q       <= ISS_FULL;
            alu_in1       <= d_in1;
            alu_in2       <= d_in2;
            alu_op        <= 3'(d_op);
            alu_invert    <= d_inv;
            ex_rd         <= rd_wr ? rd : '0;
            ex_we         <= rd_wr;
            ex_is_load    <= d_load;
            ex_is_store   <= d_store;
            ex_is_branch  <= d_branch;
            ex_is_jump    <= d_jump;
            ex_funct3     <= funct3;
            ex_store_data <= rs2_val;
            ex_imm        <= imm_x;
            ex_pc         <= id_pc;
            ex_illegal    <= d_illegal;
        end else if (ex_ready) begin
            state_q <= ISS_EMPTY;
        end
    end

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed vector bench for id_ex_issue: decode table plus forwarding/stall/flush/reset sequences.
module tb_id_ex_issue;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    localparam logic [6:0] OP    = 7'h33;
    localparam logic [6:0] OPI   = 7'h13;
    localparam logic [6:0] LUI   = 7'h37;
    localparam logic [6:0] AUIPC = 7'h17;
    localparam logic [6:0] JALR  = 7'h67;
    localparam logic [6:0] LOAD  = 7'h03;
    localparam logic [6:0] STORE = 7'h23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, flush, id_valid, id_ready, ex_valid, ex_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, ex_alu_out, mem_result, wb_result;
    logic [RA_W-1:0] mem_rd, wb_rd, ex_rd;
    logic            mem_we, wb_we, ex_we;
    logic [XLEN-1:0] alu_in1, alu_in2, ex_store_data, ex_imm, ex_pc;
    logic [2:0]      alu_op, ex_funct3;
    logic            alu_invert, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_illegal;

    id_ex_issue #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .ex_alu_out(ex_alu_out),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_invert(alu_invert),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3),
        .ex_store_data(ex_store_data), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbres;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [2:0]  op;
        logic        inv;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  cls;   // {load, store, branch, jump}
        logic [31:0] imm;
        logic [31:0] sd;
        logic        ill;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid    = 1'b0;
        flush       = 1'b0;
        ex_ready    = 1'b1;
        mem_we      = 1'b0;
        mem_rd      = '0;
        mem_result  = '0;
        wb_we       = 1'b0;
        wb_rd       = '0;
        wb_result   = '0;
        ex_alu_out  = '0;
        id_pc       = '0;
        id_rs1_data = '0;
        id_rs2_data = '0;
    endtask

    task automatic drain();
        idle_inputs();
        step();
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2);
        id_instr    = instr;
        id_rs1_data = r1;
        id_rs2_data = r2;
        id_valid    = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h0, 32'd5, 32'd7, 1'b0, 5'd0, 32'h0,
                     32'd5, 32'd7, 3'd0, 1'b0, 5'd3, 1'b1, 4'b0000, 32'h0, 32'd7, 1'b0};
        vecs[1]  = '{enc_r(7'h20, 5'd1, 5'd3, 3'd0, 5'd4, OP), 32'h0, 32'd20, 32'd8, 1'b0, 5'd0, 32'h0,
                     32'd20, 32'd8, 3'd0, 1'b1, 5'd4, 1'b1, 4'b0000, 32'h0, 32'd8, 1'b0};
        vecs[2]  = '{enc_i(12'h403, 5'd1, 3'd5, 5'd7, OPI), 32'h0, 32'h8000_0000, 32'h99, 1'b0, 5'd0, 32'h0,
                     32'h8000_0000, 32'd3, 3'd5, 1'b1, 5'd7, 1'b1, 4'b0000, 32'd3, 32'h99, 1'b0};
        vecs[3]  = '{enc_i(12'hFFF, 5'd1, 3'd0, 5'd8, OPI), 32'h0, 32'd10, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'd10, 32'hFFFF_FFFF, 3'd0, 1'b0, 5'd8, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[4]  = '{enc_b(13'h1FF8, 5'd2, 5'd1, 3'd6), 32'h0, 32'd3, 32'd9, 1'b0, 5'd0, 32'h0,
                     32'd3, 32'd9, 3'd3, 1'b0, 5'd0, 1'b0, 4'b0010, 32'hFFFF_FFF8, 32'd9, 1'b0};
        vecs[5]  = '{enc_b(13'h0010, 5'd2, 5'd1, 3'd0), 32'h0, 32'd4, 32'd4, 1'b0, 5'd0, 32'h0,
                     32'd4, 32'd4, 3'd0, 1'b1, 5'd0, 1'b0, 4'b0010, 32'd16, 32'd4, 1'b0};
        vecs[6]  = '{enc_u(20'h12345, 5'd9, LUI), 32'h0, 32'h11, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'h1234_5000, 3'd0, 1'b0, 5'd9, 1'b1, 4'b0000, 32'h1234_5000, 32'h0, 1'b0};
        vecs[7]  = '{enc_u(20'hFFFFF, 5'd10, AUIPC), 32'h1000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h1000, 32'hFFFF_F000, 3'd0, 1'b0, 5'd10, 1'b1, 4'b0000, 32'hFFFF_F000, 32'h0, 1'b0};
        vecs[8]  = '{enc_j(21'h000800, 5'd1), 32'h2000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h2000, 32'd4, 3'd0, 1'b0, 5'd1, 1'b1, 4'b0001, 32'h800, 32'h0, 1'b0};
        vecs[9]  = '{enc_s(12'hFFC, 5'd2, 5'd1, 3'd2), 32'h0, 32'h100, 32'hCAFE, 1'b0, 5'd0, 32'h0,
                     32'h100, 32'hFFFF_FFFC, 3'd0, 1'b0, 5'd0, 1'b0, 4'b0100, 32'hFFFF_FFFC, 32'hCAFE, 1'b0};
        vecs[10] = '{32'hFFFF_FFFF, 32'h0, 32'd1, 32'd2, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'h0, 3'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 32'h0, 32'd2, 1'b1};
        vecs[11] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd11, OP), 32'h0, 32'd1, 32'd2, 1'b0, 5'd0, 32'h0,
                     32'd1, 32'd2, 3'd3, 1'b0, 5'd11, 1'b1, 4'b0000, 32'h0, 32'd2, 1'b0};
        vecs[12] = '{enc_r(7'h00, 5'd2, 5'd0, 3'd0, 5'd12, OP), 32'h0, 32'h55, 32'd6, 1'b1, 5'd0, 32'hDEAD,
                     32'h0, 32'd6, 3'd0, 1'b0, 5'd12, 1'b1, 4'b0000, 32'h0, 32'd6, 1'b0};
        vecs[13] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, OP), 32'h0, 32'd1, 32'd2, 1'b0, 5'd0, 32'h0,
                     32'd1, 32'd2, 3'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 32'h0, 32'd2, 1'b0};
        vecs[14] = '{enc_i(12'd8, 5'd1, 3'd2, 5'd5, LOAD), 32'h0, 32'h111, 32'h0, 1'b1, 5'd1, 32'h300,
                     32'h300, 32'd8, 3'd0, 1'b0, 5'd5, 1'b1, 4'b1000, 32'd8, 32'h0, 1'b0};
        vecs[15] = '{enc_i(12'h004, 5'd1, 3'd5, 5'd3, OPI), 32'h0, 32'hF0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'hF0, 32'd4, 3'd5, 1'b0, 5'd3, 1'b1, 4'b0000, 32'd4, 32'h0, 1'b0};
        vecs[16] = '{enc_i(12'd12, 5'd2, 3'd0, 5'd1, JALR), 32'h40, 32'h77, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h40, 32'd4, 3'd0, 1'b0, 5'd1, 1'b1, 4'b0001, 32'd12, 32'h0, 1'b0};

        // Reset: all registered outputs zero and id_ready low while reset is asserted
        idle_inputs();
        id_instr = '0;
        reset    = 1'b1;
        id_valid = 1'b1;
        step();
        step();
        chk("rst ex_valid", 32'(ex_valid), 32'd0);
        chk("rst id_ready", 32'(id_ready), 32'd0);
        chk("rst alu_in1", alu_in1, 32'h0);
        chk("rst alu_in2", alu_in2, 32'h0);
        chk("rst flags", {25'b0, alu_op, alu_invert, ex_we, ex_is_load, ex_illegal}, 32'h0);
        reset = 1'b0;
        drain();

        // Decode table, one instruction at a time from an empty slot
        for (int i = 0; i < NVEC; i++) begin
            drain();
            issue(vecs[i].instr, vecs[i].rs1d, vecs[i].rs2d);
            id_pc     = vecs[i].pc;
            wb_we     = vecs[i].wbwe;
            wb_rd     = vecs[i].wbrd;
            wb_result = vecs[i].wbres;
            #1;
            chk($sformatf("v%0d id_ready", i), 32'(id_ready), 32'd1);
            step();
            id_valid = 1'b0;
            chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("v%0d alu_in1", i), alu_in1, vecs[i].in1);
            chk($sformatf("v%0d alu_in2", i), alu_in2, vecs[i].in2);
            chk($sformatf("v%0d alu_op", i), 32'(alu_op), 32'(vecs[i].op));
            chk($sformatf("v%0d alu_invert", i), 32'(alu_invert), 32'(vecs[i].inv));
            chk($sformatf("v%0d ex_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d ex_we", i), 32'(ex_we), 32'(vecs[i].we));
            chk($sformatf("v%0d class", i), 32'({ex_is_load, ex_is_store, ex_is_branch, ex_is_jump}),
                32'(vecs[i].cls));
            chk($sformatf("v%0d ex_imm", i), ex_imm, vecs[i].imm);
            chk($sformatf("v%0d store_data", i), ex_store_data, vecs[i].sd);
            chk($sformatf("v%0d ex_pc", i), ex_pc, vecs[i].pc);
            chk($sformatf("v%0d ex_illegal", i), 32'(ex_illegal), 32'(vecs[i].ill));
        end

        // EX forwarding beats MEM and WB writing the same register
        drain();
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'd5, 32'd7);
        step();
        issue(enc_r(7'h20, 5'd1, 5'd3, 3'd0, 5'd4, OP), 32'hBAD, 32'd2);
        ex_alu_out = 32'd12;
        mem_rd = 5'd3; mem_we = 1'b1; mem_result = 32'd99;
        wb_rd  = 5'd3; wb_we  = 1'b1; wb_result  = 32'd77;
        step();
        chk("exfwd alu_in1", alu_in1, 32'd12);
        chk("exfwd alu_in2", alu_in2, 32'd2);
        chk("exfwd invert", 32'(alu_invert), 32'd1);
        chk("exfwd ex_rd", 32'(ex_rd), 32'd4);

        // Load-use: one stall cycle, bubble, then MEM forwarding of the load result
        drain();
        issue(enc_i(12'd0, 5'd1, 3'd2, 5'd5, LOAD), 32'h200, 32'h0);
        step();
        chk("lw is_load", 32'(ex_is_load), 32'd1);
        chk("lw funct3", 32'(ex_funct3), 32'd2);
        chk("lw alu_in1", alu_in1, 32'h200);
        issue(enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6, OP), 32'hBAD, 32'hBAD);
        ex_alu_out = 32'h200;
        #1;
        chk("lu id_ready stall", 32'(id_ready), 32'd0);
        step();
        chk("lu bubble ex_valid", 32'(ex_valid), 32'd0);
        mem_rd = 5'd5; mem_we = 1'b1; mem_result = 32'h1234;
        #1;
        chk("lu id_ready resume", 32'(id_ready), 32'd1);
        step();
        chk("lu ex_valid", 32'(ex_valid), 32'd1);
        chk("lu alu_in1", alu_in1, 32'h1234);
        chk("lu alu_in2", alu_in2, 32'h1234);
        chk("lu ex_rd", 32'(ex_rd), 32'd6);

        // Backpressure: outputs hold for three cycles, then the waiting instr is accepted
        drain();
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'd5, 32'd7);
        step();
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd9, OP), 32'd1, 32'd2);
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d id_ready", k), 32'(id_ready), 32'd0);
            step();
            chk($sformatf("bp%0d ex_valid", k), 32'(ex_valid), 32'd1);
            chk($sformatf("bp%0d alu_in1", k), alu_in1, 32'd5);
            chk($sformatf("bp%0d alu_in2", k), alu_in2, 32'd7);
            chk($sformatf("bp%0d ex_rd", k), 32'(ex_rd), 32'd3);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp release id_ready", 32'(id_ready), 32'd1);
        step();
        chk("bp next alu_op", 32'(alu_op), 32'd6);
        chk("bp next alu_in1", alu_in1, 32'd1);
        chk("bp next ex_rd", 32'(ex_rd), 32'd9);

        // Flush while FULL with a new instr offered: slot empties, instr dropped
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'd5, 32'd7);
        ex_ready = 1'b0;
        flush    = 1'b1;
        #1;
        chk("flush id_ready", 32'(id_ready), 32'd0);
        step();
        flush    = 1'b0;
        id_valid = 1'b0;
        chk("flush ex_valid", 32'(ex_valid), 32'd0);

        // Reset during a load-use stall wins over everything
        drain();
        issue(enc_i(12'd0, 5'd1, 3'd2, 5'd5, LOAD), 32'h200, 32'h0);
        step();
        issue(enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6, OP), 32'hBAD, 32'hBAD);
        ex_ready = 1'b0;
        step();
        chk("stall ex_valid", 32'(ex_valid), 32'd1);
        chk("stall id_ready", 32'(id_ready), 32'd0);
        reset = 1'b1;
        step();
        chk("rst-stall ex_valid", 32'(ex_valid), 32'd0);
        chk("rst-stall alu_in1", alu_in1, 32'h0);
        chk("rst-stall ex_rd", 32'(ex_rd), 32'd0);
        chk("rst-stall is_load", 32'(ex_is_load), 32'd0);
        chk("rst-stall id_ready", 32'(id_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("post-rst id_ready", 32'(id_ready), 32'd1);
        step();
        chk("post-rst ex_valid", 32'(ex_valid), 32'd1);
        chk("post-rst alu_in1", alu_in1, 32'hBAD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
